falu_sequencer: RTL

Command-side front end for the floating-point ALU. Accepts FP operation descriptors over a valid/ready handshake and buffers them in a small FIFO. Issues them one at a time to the ALU's start/operand interface, captures result and flags on the ALU's valid strobe, and presents them tagged on a valid/ready result port. Also maintains a sticky exception-flag register (IEEE-style accrued flags) for the CPU.

---
 rtl/falu_sequencer_if.sv | 43 ++++
 rtl/falu_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/falu_sequencer_if.sv
// Command, ALU and result signal bundle for falu_sequencer.
// The sequencer takes the slave view; the CPU/ALU side (or a bench) takes the master view.
interface falu_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [1:0]  cmd_op;
  logic        cmd_mode;
  logic        cmd_round;
  logic [3:0]  cmd_tag;
  logic        alu_start;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [1:0]  alu_op_code;
  logic        alu_mode_fp;
  logic        alu_round_mode;
  logic [31:0] alu_result;
  logic [4:0]  alu_flags;
  logic        alu_valid;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_flags;
  logic [3:0]  res_tag;
  logic [4:0]  sticky_flags;
  logic        sticky_clr;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_mode, cmd_round, cmd_tag,
    input  alu_result, alu_flags, alu_valid, res_ready, sticky_clr,
    output cmd_ready, alu_start, alu_op_a, alu_op_b, alu_op_code, alu_mode_fp,
    output alu_round_mode, res_valid, res_data, res_flags, res_tag, sticky_flags, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_mode, cmd_round, cmd_tag,
    output alu_result, alu_flags, alu_valid, res_ready, sticky_clr,
    input  cmd_ready, alu_start, alu_op_a, alu_op_b, alu_op_code, alu_mode_fp,
    input  alu_round_mode, res_valid, res_data, res_flags, res_tag, sticky_flags, busy
  );
endinterface

// File: rtl/falu_sequencer.sv
// FP ALU command sequencer: command FIFO, issue/wait/done FSM, result hold and sticky flags.
// Optional ALU watchdog compiled in with `define FALU_SEQ_TIMEOUT_EN.
module falu_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  falu_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [71:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [71:0] op_q, op_d;
  logic [31:0] res_data_q, res_data_d;
  logic [4:0]  res_flags_q, res_flags_d;
  logic [3:0]  res_tag_q, res_tag_d;
  logic [4:0]  sticky_q, sticky_d;
  logic [71:0] cmd_entry;
  logic        empty, full, push, pop, capture;
  logic [31:0] cap_data;
  logic [4:0]  cap_flags;

`ifdef FALU_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Entry layout: {tag, round, mode, op, b, a}
  assign cmd_entry = {bus.cmd_tag, bus.cmd_round, bus.cmd_mode, bus.cmd_op, bus.cmd_b, bus.cmd_a};
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = bus.cmd_valid && bus.cmd_ready;
  assign wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

  assign bus.cmd_ready      = !rst && !full;
  assign bus.alu_start      = (state_q == ISSUE);
  assign bus.alu_op_a       = op_q[31:0];
  assign bus.alu_op_b       = op_q[63:32];
  assign bus.alu_op_code    = op_q[65:64];
  assign bus.alu_mode_fp    = op_q[66];
  assign bus.alu_round_mode = op_q[67];
  assign bus.res_valid      = (state_q == DONE);
  assign bus.res_data       = res_data_q;
  assign bus.res_flags      = res_flags_q;
  assign bus.res_tag        = res_tag_q;
  assign bus.sticky_flags   = sticky_q;
  assign bus.busy           = !empty || (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    op_d        = op_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_tag_d   = res_tag_q;
    sticky_d    = sticky_q;
    pop         = 1'b0;
    capture     = 1'b0;
    cap_data    = bus.alu_result;
    cap_flags   = bus.alu_flags;
`ifdef FALU_SEQ_TIMEOUT_EN
    wd_d        = wd_q;
`endif

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.alu_valid) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.alu_valid) begin
          capture = 1'b1;
          state_d = DONE;
        end
`ifdef FALU_SEQ_TIMEOUT_EN
        // Watchdog expiry returns a quiet NaN of the command's width, flagged invalid.
        else if (wd_q == WDW'(TIMEOUT - 1)) begin
          capture   = 1'b1;
          cap_data  = op_q[66] ? 32'h7FC0_0000 : 32'h0000_7E00;
          cap_flags = 5'b10000;
          state_d   = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.res_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      op_d     = fifo_mem[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (capture) begin
      res_data_d  = cap_data;
      res_flags_d = cap_flags;
      res_tag_d   = op_q[71:68];
    end

    // A clear coinciding with a capture clears first, then accrues the new flags.
    if (capture) begin
      sticky_d = (bus.sticky_clr ? 5'b0 : sticky_q) | cap_flags;
    end else if (bus.sticky_clr) begin
      sticky_d = 5'b0;
    end

`ifdef FALU_SEQ_TIMEOUT_EN
    if (pop) begin
      wd_d = '0;
    end else if (state_q == ISSUE || state_q == WAIT) begin
      wd_d = wd_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= cmd_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      op_q        <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_tag_q   <= '0;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      op_q        <= op_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_tag_q   <= res_tag_d;
      sticky_q    <= sticky_d;
    end
  end

`ifdef FALU_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif
endmodule
